// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared writeback-port constants
// Purpose: default widths, the hard-wired zero register address and the
//          requester index map shared by the writeback-side arbiters.
// Ports:   none (package)
package wb_pkg;

  localparam int WB_DW   = 16;  // result data width
  localparam int WB_AW   = 3;   // register address width (8 registers)
  localparam int WB_NREQ = 3;   // number of result producers

  localparam int R0_ADDR = 0;   // R0 reads as zero; writes to it are discarded

  localparam int WB_ALU = 0;
  localparam int WB_DM  = 1;
  localparam int WB_IO  = 2;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - requester and register-file write port bundle
// Purpose: groups the producer valid/ready handshake, the register-file
//          hold input and the registered write port.
// Ports:   master - producers / register file side (drives requests, hold)
//          slave  - arbiter side (drives ready, write port, drop_cnt)
interface wb_port_arbiter_if
  import wb_pkg::*;
#(
  parameter int DW   = WB_DW,
  parameter int AW   = WB_AW,
  parameter int NREQ = WB_NREQ
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_ready;
  logic               hold;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;
  logic [7:0]         drop_cnt;

  modport master (
    output req_valid, req_data, req_addr, hold,
    input  req_ready, rf_we, rf_waddr, rf_wdata, drop_cnt
  );

  modport slave (
    input  req_valid, req_data, req_addr, hold,
    output req_ready, rf_we, rf_waddr, rf_wdata, drop_cnt
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority encoder
// Purpose: finds the first set bit of req searching upward from ptr and
//          wrapping modulo N; shared with the memory-port arbiter.
// Ports:   req       in  N   request vector
//          ptr       in  PW  highest-priority index (0..N-1)
//          gnt_valid out 1   any request present
//          gnt_idx   out PW  winning index
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          gnt_valid,
  output logic [PW-1:0] gnt_idx
);

  localparam int SW = PW + 1;

  logic [SW-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest valid index
  // (lowest rotation from ptr) is the last one written and wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    pos       = '0;
    for (int off = N - 1; off >= 0; off--) begin
      pos = {1'b0, ptr} + SW'(off);
      if (pos >= SW'(N)) pos = pos - SW'(N);
      if (req[pos[PW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin arbiter for the register-file write port
// Purpose: grants one result producer per cycle (round-robin) and registers
//          the winner onto the register-file write port; R0 writes are
//          consumed without a write and counted in drop_cnt (saturating).
// Ports:   clk   in  clock, rising edge
//          reset in  asynchronous active-high reset
//          bus   slave modport of wb_port_arbiter_if
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DW   = WB_DW,
  parameter int AW   = WB_AW,
  parameter int NREQ = WB_NREQ
) (
  input  logic               clk,
  input  logic               reset,
  wb_port_arbiter_if.slave   bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic          gnt_valid;
  logic          xfer;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;
  logic          is_r0;

  logic          rf_we_q;
  logic [AW-1:0] rf_waddr_q;
  logic [DW-1:0] rf_wdata_q;
  logic [7:0]    drop_cnt_q;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // hold only suppresses the grant; the winner is still computed.
  assign xfer  = gnt_valid & ~bus.hold;
  assign is_r0 = (win_addr == AW'(R0_ADDR));

  // Constant-index mux keeps data/addr off the ready path.
  always_comb begin
    bus.req_ready = '0;
    win_addr      = '0;
    win_data      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == PW'(i)) begin
        bus.req_ready[i] = xfer;
        win_addr         = bus.req_addr[i*AW +: AW];
        win_data         = bus.req_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      rf_we_q <= 1'b0;
      if (xfer) begin
        ptr        <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
        rf_waddr_q <= win_addr;
        rf_wdata_q <= win_data;
        rf_we_q    <= ~is_r0;
        if (is_r0 && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed scoreboard bench for wb_port_arbiter
module tb_wb_port_arbiter;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DW(16), .AW(3), .NREQ(3)) bus ();

  wb_port_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        we;
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         sb_q[$];
  int          tests = 0;
  int          fails = 0;
  int          m_ptr = 0;
  int          m_drop = 0;
  logic [2:0]  m_addr = '0;
  logic [15:0] m_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant(input logic [2:0] v, input int p);
    for (int off = 0; off < 3; off++) begin
      if (v[(p + off) % 3]) return (p + off) % 3;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [15:0] d, input logic [2:0] a);
    bus.req_data[i*16 +: 16] = d;
    bus.req_addr[i*3 +: 3]   = a;
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_drop = 0;
    m_addr = '0;
    m_data = '0;
    sb_q.delete();
  endtask

  // One clock: check ready mid-cycle, push the expected write, check the
  // registered port just after the edge.
  task automatic cycle(input string tag);
    int          g;
    logic [2:0]  rdy;
    wr_t         w;
    wr_t         e;
    @(negedge clk);
    g   = bus.hold ? -1 : exp_grant(bus.req_valid, m_ptr);
    rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'(rdy));
    if (g >= 0) begin
      m_addr = bus.req_addr[g*3 +: 3];
      m_data = bus.req_data[g*16 +: 16];
      w.we   = (m_addr != 3'(R0_ADDR));
      if (m_addr == 3'(R0_ADDR) && m_drop < 255) m_drop++;
      m_ptr  = (g + 1) % 3;
    end else begin
      w.we = 1'b0;
    end
    w.addr = m_addr;
    w.data = m_data;
    sb_q.push_back(w);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".rf_we"},    32'(bus.rf_we),    32'(e.we));
    chk({tag, ".rf_waddr"}, 32'(bus.rf_waddr), 32'(e.addr));
    chk({tag, ".rf_wdata"}, 32'(bus.rf_wdata), 32'(e.data));
    chk({tag, ".drop_cnt"}, 32'(bus.drop_cnt), 32'(m_drop));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".rf_we"},    32'(bus.rf_we),    32'd0);
    chk({tag, ".rf_waddr"}, 32'(bus.rf_waddr), 32'd0);
    chk({tag, ".rf_wdata"}, 32'(bus.rf_wdata), 32'd0);
    chk({tag, ".drop_cnt"}, 32'(bus.drop_cnt), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with all producers valid.
    reset         = 1'b1;
    bus.hold      = 1'b0;
    bus.req_valid = 3'b111;
    set_req(WB_ALU, 16'h0003, 3'd1);
    set_req(WB_DM,  16'h0008, 3'd2);
    set_req(WB_IO,  16'h0002, 3'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", 32'(bus.req_ready), 32'(3'b001));
    chk_zero_outputs("rst");

    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Round robin: grants 0,1,2,0,1,2 with data 3,8,2 repeating.
    for (int i = 0; i < 6; i++) cycle("rr");

    // Single DM requester, then idle.
    bus.req_valid = 3'b010;
    set_req(WB_DM, 16'h0005, 3'd3);
    cycle("single");
    bus.req_valid = 3'b000;
    cycle("single_idle");

    // Hold for two cycles with ALU valid, then grant.
    bus.req_valid = 3'b001;
    set_req(WB_ALU, 16'h0011, 3'd4);
    bus.hold = 1'b1;
    cycle("hold");
    cycle("hold");
    bus.hold = 1'b0;
    cycle("hold_rel");

    // Hold with everyone valid: pointer must survive the hold.
    bus.req_valid = 3'b111;
    bus.hold = 1'b1;
    cycle("hold_all");
    bus.hold = 1'b0;
    cycle("hold_all_rel");
    bus.req_valid = 3'b000;
    cycle("idle");

    // R0 writes: consumed, no write, counter saturates.
    bus.req_valid = 3'b001;
    set_req(WB_ALU, 16'h0001, 3'd0);
    for (int i = 0; i < 300; i++) cycle("r0");
    chk("r0.sat", 32'(bus.drop_cnt), 32'd255);

    // Reset mid-stream.
    bus.req_valid = 3'b111;
    set_req(WB_ALU, 16'h0003, 3'd1);
    for (int i = 0; i < 2; i++) cycle("pre_rst");
    chk("pre_rst.we_high", 32'(bus.rf_we), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_zero_outputs("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) cycle("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port of the 16-bit processor's writeback stage among several result producers: ALU, data-memory load path and I/O/immediate path. Each producer offers a result plus destination register through a valid/ready handshake. One is granted per cycle by round-robin, and the winner is driven registered onto the register-file write port. The block sits between the execute/memory stages and the register file, downstream of the writeback datapath.

## Interface
Parameters:
- `DW`, 16, result data width
- `AW`, 3, register address width (8 registers)
- `NREQ`, 3, number of requesters (index 0 = ALU, 1 = data memory, 2 = I/O/immediate)

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  NREQ  requester i holds a result
- `req_data`  in  NREQ*DW  result of requester i in bits [i*DW +: DW]
- `req_addr`  in  NREQ*AW  destination register of requester i in bits [i*AW +: AW]
- `req_ready`  out  NREQ  one-hot or zero; requester i is granted this cycle
- `hold`  in  1  register file cannot accept a write; no grant is issued
- `rf_we`  out  1  register-file write enable
- `rf_waddr`  out  AW  register-file write address
- `rf_wdata`  out  DW  register-file write data
- `drop_cnt`  out  8  count of granted writes targeting R0

## Operation
- State:
  - Round-robin pointer `ptr` in 0..NREQ-1.
  - Output registers `rf_we`, `rf_waddr`, `rf_wdata`.
  - Saturating counter `drop_cnt`.
- Arbitration, combinational within the cycle:
  - Search `req_valid` starting at index `ptr`, wrapping modulo NREQ.
  - The first valid index found is the winner `g`.
  - `req_ready[g]=1` only if `hold=0`; all other ready bits are 0.
  - When `hold=1` or no valid is present, `req_ready` is all zeros.
- Transfer:
  - A transfer occurs when `req_valid[g] & req_ready[g]`.
  - The requester must keep valid, data and address stable until it is granted.
- On transfer at edge k:
  - `ptr <= (g+1) mod NREQ`.
  - `rf_waddr <= req_addr[g]`.
  - `rf_wdata <= req_data[g]`.
  - `rf_we <= (req_addr[g] != 0)`.
- R0 writes: R0 is hard-wired zero.
  - A grant targeting address 0 is consumed (ready=1) but produces `rf_we=0`.
  - It increments `drop_cnt`, which saturates at 255.
- No transfer in a cycle:
  - `rf_we <= 0`.
  - `rf_waddr`/`rf_wdata` hold their last value.
  - `ptr` is unchanged.
- Reset (asynchronous, at any time, including mid-transfer):
  - `ptr=0`, `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `drop_cnt=0`.
  - A grant in the same cycle that reset asserts is lost. Requesters re-present after reset release.
- Fairness: a continuously valid requester is granted within NREQ transfers.

## Timing
- `req_ready` is combinational from `req_valid`, `ptr` and `hold`. There is no combinational path from `req_data`/`req_addr`.
- Latency: transfer in cycle k → `rf_we`/`rf_waddr`/`rf_wdata` valid during cycle k+1. `rf_we` is a single-cycle pulse per granted non-R0 write.
- Throughput: one write per cycle.
- `hold` takes effect in the same cycle. A write already registered (`rf_we=1`) is not retracted by `hold`.
- Simultaneous valids: exactly one grant per cycle; the others wait.
- Pointer wrap: a grant to index NREQ-1 sets `ptr=0`.

## Structure
- Shared package `wb_pkg`:
  - Default `DW`, `AW`, `NREQ`.
  - Constant `R0_ADDR = 0`.
  - Requester index constants `WB_ALU`, `WB_DM`, `WB_IO`.
- Sub-module `rr_pick`: combinational rotate-priority encoder. Inputs `req` and `ptr`; outputs `gnt_valid` and `gnt_idx`. It is reusable by the memory-port arbiter.
- The top level holds `ptr`, the output registers and `drop_cnt`.

## Test plan
- Reset value check:
  - During reset with all `req_valid=3'b111`: `req_ready` is computed from `ptr=0`, and all outputs are 0.
  - After release: first grant goes to index 0.
- Single requester:
  - Stimulus: DM valid with data 0x0005, addr 3.
  - Response: `req_ready=3'b010` in cycle k; `rf_we=1`, `rf_waddr=3`, `rf_wdata=0x0005` in cycle k+1; `rf_we=0` in k+2 once valid drops.
- Round-robin: all three valid every cycle with data 0x0003 / 0x0008 / 0x0002 → grants 0,1,2,0,1,2; `rf_wdata` sequence 0x0003, 0x0008, 0x0002 repeating.
- Hold:
  - Stimulus: `hold=1` for 2 cycles while ALU is valid.
  - Response: `req_ready=0` and `ptr` unchanged during the hold; ALU granted in the first cycle after `hold` drops.
- R0 drop: ALU writes 0x0001 to addr 0 → `req_ready[0]=1`, `rf_we` stays 0, `drop_cnt` goes to 1. After 300 such writes, `drop_cnt=255`.
- Reset mid-stream: assert `reset` during a continuous round-robin sequence → outputs return to 0 immediately (asynchronously). After release, grant order restarts at index 0.
